spi_txn_arbiter: RTL



---
 rtl/spi_txn_arbiter_pkg.sv | 26 ++
 rtl/spi_txn_arbiter_if.sv | 51 +++++
 rtl/spi_txn_arbiter_rr.sv | 26 ++
 rtl/spi_txn_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/spi_txn_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared types and constants for the SPI transaction arbiter slice.
//   arb_state_t  : sequencing states of the arbiter controller
//   REQ_SENSOR   : requester id of the sensor poll path
//   REQ_DISPLAY  : requester id of the display/command path
//   idToOneHot() : turns a requester id into a 2-bit one-hot vector
// ---------------------------------------------------------------------------
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE,
    COMPLETE
  } arb_state_t;

  localparam logic REQ_SENSOR  = 1'b0;
  localparam logic REQ_DISPLAY = 1'b1;

  function automatic logic [1:0] idToOneHot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter_if
// Bundles the requester-side handshake and the SPI-master-side signals of the
// arbiter.
//   Requester side : req, tx0/tx1_bytes, tx0/tx1_cnt, rx0/rx1_cnt (to arbiter)
//                    gnt, done, err, rx_bytes, busy (from arbiter)
//   SPI side       : spi_start, spi_in_bytes, spi_in_cnt, spi_out_cnt
//                    (from arbiter), spi_trans_done, spi_out_bytes (to arbiter)
// Modports:
//   master : the arbiter itself (it masters the shared SPI engine)
//   slave  : everything around it (requesters and the SPI master)
// ---------------------------------------------------------------------------
interface spi_txn_arbiter_if #(
  parameter int BUFFER_BYTES = 4,
  parameter int CNT_W        = $clog2(BUFFER_BYTES) + 1
);

  logic [1:0]                req;
  logic [BUFFER_BYTES*8-1:0] tx0_bytes;
  logic [BUFFER_BYTES*8-1:0] tx1_bytes;
  logic [CNT_W-1:0]          tx0_cnt;
  logic [CNT_W-1:0]          tx1_cnt;
  logic [CNT_W-1:0]          rx0_cnt;
  logic [CNT_W-1:0]          rx1_cnt;
  logic [1:0]                gnt;
  logic [1:0]                done;
  logic [1:0]                err;
  logic [BUFFER_BYTES*8-1:0] rx_bytes;
  logic                      busy;
  logic                      spi_start;
  logic [BUFFER_BYTES*8-1:0] spi_in_bytes;
  logic [CNT_W-1:0]          spi_in_cnt;
  logic [CNT_W-1:0]          spi_out_cnt;
  logic                      spi_trans_done;
  logic [BUFFER_BYTES*8-1:0] spi_out_bytes;

  modport master (
    input  req, tx0_bytes, tx1_bytes, tx0_cnt, tx1_cnt, rx0_cnt, rx1_cnt,
    input  spi_trans_done, spi_out_bytes,
    output gnt, done, err, rx_bytes, busy,
    output spi_start, spi_in_bytes, spi_in_cnt, spi_out_cnt
  );

  modport slave (
    output req, tx0_bytes, tx1_bytes, tx0_cnt, tx1_cnt, rx0_cnt, rx1_cnt,
    output spi_trans_done, spi_out_bytes,
    input  gnt, done, err, rx_bytes, busy,
    input  spi_start, spi_in_bytes, spi_in_cnt, spi_out_cnt
  );

endinterface

// File: rtl/spi_txn_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin pick.
//   i_req  : request levels of the two requesters
//   i_last : id of the requester that was served most recently
//   o_gnt  : one-hot winner (all zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_arbiter2
  import spi_ctrl_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // A lone requester simply wins; on a tie the one that was not served last
  // goes next, so neither path can starve the other.
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (i_last == REQ_SENSOR) ? idToOneHot(REQ_DISPLAY)
                                     : idToOneHot(REQ_SENSOR);
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter
// Shares one SPI master between the sensor poll path (requester 0) and the
// display/command path (requester 1). Picks a winner round-robin, latches its
// operands, toggles the SPI master's start line, follows trans_done through
// its fall and rise and hands back the read bytes with a one-cycle done pulse.
//   clk : clock, same net as the SPI master's sck_in
//   rst : synchronous active-high reset
//   bus : spi_txn_arbiter_if.master (requester and SPI master signals)
// Parameters:
//   BUFFER_BYTES   : SPI buffer depth in bytes (must match the SPI master)
//   CNT_W          : width of the byte-count fields
//   TIMEOUT_CYCLES : longest wait allowed in WAIT_ACK or WAIT_DONE
// ---------------------------------------------------------------------------
module spi_txn_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int BUFFER_BYTES   = 4,
  parameter int CNT_W          = $clog2(BUFFER_BYTES) + 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  spi_txn_arbiter_if.master bus
);

  localparam int               DataW  = BUFFER_BYTES * 8;
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(BUFFER_BYTES);
  localparam int               ToW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ToW-1:0]   ToLast = ToW'(TIMEOUT_CYCLES - 1);

  arb_state_t       r_state;
  logic             r_last;
  logic             r_owner;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic [1:0]       r_err;
  logic             r_busy;
  logic             r_spiStart;
  logic [DataW-1:0] r_spiInBytes;
  logic [CNT_W-1:0] r_spiInCnt;
  logic [CNT_W-1:0] r_spiOutCnt;
  logic [DataW-1:0] r_rxBytes;
  logic [ToW-1:0]   r_toCnt;

  logic [1:0]       w_pick;
  logic             w_winner;
  logic [1:0]       w_ownerHot;
  logic [DataW-1:0] w_txBytes;
  logic [CNT_W-1:0] w_txCnt;
  logic [CNT_W-1:0] w_rxCnt;

  function automatic logic [CNT_W-1:0] clampCnt(input logic [CNT_W-1:0] cnt);
    return (cnt > MaxCnt) ? MaxCnt : cnt;
  endfunction

  rr_arbiter2 u_rr (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // The winner's id is the upper bit of the one-hot pick; it steers which
  // operand set gets latched.
  assign w_winner   = w_pick[1];
  assign w_ownerHot = idToOneHot(r_owner);
  assign w_txBytes  = w_winner ? bus.tx1_bytes : bus.tx0_bytes;
  assign w_txCnt    = w_winner ? bus.tx1_cnt   : bus.tx0_cnt;
  assign w_rxCnt    = w_winner ? bus.rx1_cnt   : bus.rx0_cnt;

  // Controller. done/err/rx_bytes are loaded on the way into COMPLETE so the
  // pulse is visible during the COMPLETE cycle, one cycle after trans_done
  // rises. IDLE only arbitrates while the SPI master reports idle, which also
  // keeps us from launching on top of a transfer orphaned by a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last       <= REQ_DISPLAY;
      r_owner      <= REQ_SENSOR;
      r_gnt        <= '0;
      r_done       <= '0;
      r_err        <= '0;
      r_busy       <= 1'b0;
      r_spiStart   <= 1'b0;
      r_spiInBytes <= '0;
      r_spiInCnt   <= '0;
      r_spiOutCnt  <= '0;
      r_rxBytes    <= '0;
      r_toCnt      <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        IDLE: begin
          if (bus.req != 2'b00 && bus.spi_trans_done) begin
            r_owner      <= w_winner;
            r_gnt        <= w_pick;
            r_spiInBytes <= w_txBytes;
            r_spiInCnt   <= clampCnt(w_txCnt);
            r_spiOutCnt  <= clampCnt(w_rxCnt);
            r_busy       <= 1'b1;
            r_state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (r_spiInCnt == '0 && r_spiOutCnt == '0) begin
            r_rxBytes <= bus.spi_out_bytes;
            r_done    <= w_ownerHot;
            r_state   <= COMPLETE;
          end else begin
            r_spiStart <= ~r_spiStart;
            r_toCnt    <= '0;
            r_state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!bus.spi_trans_done) begin
            r_toCnt <= '0;
            r_state <= WAIT_DONE;
          end else if (r_toCnt == ToLast) begin
            r_done  <= w_ownerHot;
            r_err   <= w_ownerHot;
            r_state <= COMPLETE;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (bus.spi_trans_done) begin
            r_rxBytes <= bus.spi_out_bytes;
            r_done    <= w_ownerHot;
            r_state   <= COMPLETE;
          end else if (r_toCnt == ToLast) begin
            r_done  <= w_ownerHot;
            r_err   <= w_ownerHot;
            r_state <= COMPLETE;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        COMPLETE: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_last  <= r_owner;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Everything leaving the block comes straight from registers.
  assign bus.gnt          = r_gnt;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.rx_bytes     = r_rxBytes;
  assign bus.busy         = r_busy;
  assign bus.spi_start    = r_spiStart;
  assign bus.spi_in_bytes = r_spiInBytes;
  assign bus.spi_in_cnt   = r_spiInCnt;
  assign bus.spi_out_cnt  = r_spiOutCnt;

endmodule
